vspi_rx: RTL and testbench

SPI mode-0 slave receiver on the host link (Sclk/Mosi/Csel). It decodes host command frames into single-byte video-memory write requests for the vmmu write port. Receive-only: the host SPI master is the transmitter, and this block is the receiving end. All logic runs in the MemClk domain; SPI pins are oversampled.

---
 rtl/vspi_pkg.sv | 26 ++
 rtl/vspi_rx_if.sv | 12 +
 rtl/vsync.sv | 31 +++
 rtl/vspi_rx.sv | 141 ++++++++++++++
 tb/tb_vspi_rx.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/vspi_pkg.sv
// rtl/vspi_pkg.sv - shared types, default opcodes and byte-insert helper for the SPI receiver
package vspi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR2,
        ADDR1,
        ADDR0,
        DATA,
        DISCARD
    } state_t;

    localparam logic [7:0] CMD_WRITE_DEF = 8'h01;
    localparam logic [7:0] CMD_NOP_DEF   = 8'h00;

    // Replace byte lane idx (0 = bits 7:0) of a 24-bit address word.
    function automatic logic [23:0] put_byte(input logic [23:0] a, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [23:0] r;
        r = a;
        r[idx*8 +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/vspi_rx_if.sv
// rtl/vspi_rx_if.sv - single-byte video-memory write request channel
interface vspi_rx_if #(
    parameter int AWIDTH = 19
);
    logic              WrValid;
    logic              WrReady;
    logic [AWIDTH-1:0] WrAddr;
    logic [7:0]        WrData;

    modport master (output WrValid, output WrAddr, output WrData, input WrReady);
    modport slave  (input WrValid, input WrAddr, input WrData, output WrReady);
endinterface

// File: rtl/vsync.sv
// rtl/vsync.sv - flop-chain synchronizer with registered rise/fall pulses
module vsync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~prev;
            fall  <= ~chain[STAGES-1] & prev;
        end
    end

    assign dout = chain[STAGES-1];
endmodule

// File: rtl/vspi_rx.sv
// rtl/vspi_rx.sv - SPI mode-0 slave that turns host write frames into vmmu byte writes
module vspi_rx
    import vspi_pkg::*;
#(
    parameter int         AWIDTH      = 19,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CMD_WRITE   = CMD_WRITE_DEF,
    parameter logic [7:0] CMD_NOP     = CMD_NOP_DEF
) (
    input  logic       MemClk,
    input  logic       ResetN,
    input  logic       Sclk,
    input  logic       Mosi,
    input  logic       Csel,
    input  logic       ClearErr,
    vspi_rx_if.master  wr,
    output logic       Overrun,
    output logic       FrameErr,
    output logic       Busy
);
    localparam logic [AWIDTH-1:0] ADDR_ONE = 1;

    logic sclk_rise, sclk_unused_lvl, sclk_unused_fall;
    logic mosi_lvl, mosi_unused_rise, mosi_unused_fall;
    logic csel_lvl, csel_rise, csel_fall;

    vsync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(MemClk), .rst_n(ResetN), .din(Sclk),
        .dout(sclk_unused_lvl), .rise(sclk_rise), .fall(sclk_unused_fall));
    vsync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(MemClk), .rst_n(ResetN), .din(Mosi),
        .dout(mosi_lvl), .rise(mosi_unused_rise), .fall(mosi_unused_fall));
    vsync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csel (
        .clk(MemClk), .rst_n(ResetN), .din(Csel),
        .dout(csel_lvl), .rise(csel_rise), .fall(csel_fall));

    assign Busy = ~csel_lvl;

    // Byte assembly; a completed byte is presented one cycle later as byte_stb/byte_q.
    logic [7:0] sr, byte_q;
    logic [2:0] cnt;
    logic       byte_stb;

    always_ff @(posedge MemClk or negedge ResetN) begin
        if (!ResetN) begin
            sr       <= '0;
            cnt      <= '0;
            byte_q   <= '0;
            byte_stb <= 1'b0;
        end else begin
            byte_stb <= 1'b0;
            if (csel_fall || csel_rise) begin
                cnt <= '0;
            end else if (sclk_rise && !csel_lvl) begin
                sr  <= {sr[6:0], mosi_lvl};
                cnt <= cnt + 3'd1;
                if (cnt == 3'd7) begin
                    byte_stb <= 1'b1;
                    byte_q   <= {sr[6:0], mosi_lvl};
                end
            end
        end
    end

    state_t state, state_nxt;

    always_ff @(posedge MemClk or negedge ResetN) begin
        if (!ResetN) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (csel_rise) begin
            state_nxt = IDLE;
        end else if (csel_fall) begin
            state_nxt = CMD;
        end else if (byte_stb) begin
            case (state)
                CMD:     state_nxt = (byte_q == CMD_WRITE) ? ADDR2 : DISCARD;
                ADDR2:   state_nxt = ADDR1;
                ADDR1:   state_nxt = ADDR0;
                ADDR0:   state_nxt = DATA;
                default: state_nxt = state;
            endcase
        end
    end

    logic       byte_ev, addr_ld, data_ev, bad_op;
    logic [1:0] addr_lane;

    always_comb begin
        byte_ev   = byte_stb && !csel_rise && !csel_fall;
        addr_ld   = 1'b0;
        addr_lane = 2'd0;
        data_ev   = 1'b0;
        bad_op    = 1'b0;
        case (state)
            CMD:     bad_op = byte_ev && (byte_q != CMD_WRITE) && (byte_q != CMD_NOP);
            ADDR2:   begin addr_ld = byte_ev; addr_lane = 2'd2; end
            ADDR1:   begin addr_ld = byte_ev; addr_lane = 2'd1; end
            ADDR0:   begin addr_ld = byte_ev; addr_lane = 2'd0; end
            DATA:    data_ev = byte_ev;
            default: ;
        endcase
    end

    logic [AWIDTH-1:0] addr;
    logic [23:0]       addr_wide;
    logic              ov_set, fe_set;

    assign addr_wide = {{(24-AWIDTH){1'b0}}, addr};
    assign ov_set    = data_ev && wr.WrValid && !wr.WrReady;
    assign fe_set    = bad_op || (csel_rise && (cnt != 3'd0));

    always_ff @(posedge MemClk or negedge ResetN) begin
        if (!ResetN) begin
            addr       <= '0;
            wr.WrValid <= 1'b0;
            wr.WrAddr  <= '0;
            wr.WrData  <= '0;
            Overrun    <= 1'b0;
            FrameErr   <= 1'b0;
        end else begin
            if (addr_ld) addr <= AWIDTH'(put_byte(addr_wide, addr_lane, byte_q));
            else if (data_ev) addr <= addr + ADDR_ONE;

            // The address advances even when the byte is dropped on overrun.
            if (data_ev && (!wr.WrValid || wr.WrReady)) begin
                wr.WrValid <= 1'b1;
                wr.WrAddr  <= addr;
                wr.WrData  <= byte_q;
            end else if (wr.WrReady) begin
                wr.WrValid <= 1'b0;
            end

            Overrun  <= ov_set | (Overrun & ~ClearErr);
            FrameErr <= fe_set | (FrameErr & ~ClearErr);
        end
    end
endmodule

// File: tb/tb_vspi_rx.sv
// tb/tb_vspi_rx.sv - directed bench for vspi_rx with immediate-assertion checks
module tb_vspi_rx;
    import vspi_pkg::*;

    logic clk = 1'b0;
    logic rst_n, sclk, mosi, csel, clear_err;
    logic overrun, frame_err, busy;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    logic [26:0] cap_q[$];

    vspi_rx_if #(.AWIDTH(19)) wr ();

    vspi_rx #(.AWIDTH(19), .SYNC_STAGES(2)) dut (
        .MemClk(clk), .ResetN(rst_n), .Sclk(sclk), .Mosi(mosi), .Csel(csel),
        .ClearErr(clear_err), .wr(wr), .Overrun(overrun), .FrameErr(frame_err), .Busy(busy));

    always #10 clk = ~clk;

    always @(posedge clk)
        if (rst_n && wr.WrValid && wr.WrReady) cap_q.push_back({wr.WrAddr, wr.WrData});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mode 0, Sclk = MemClk/8; optional latency measurement on the final bit.
    task automatic send_bits(input logic [7:0] b, input int nbits, input bit measure);
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = b[i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            if (measure && i == 0) begin
                for (int c = 0; c < 8; c++) begin
                    @(negedge clk);
                    if (lat < 0 && wr.WrValid) lat = c;
                    if (c == 3) sclk = 1'b0;
                end
            end else begin
                repeat (4) @(negedge clk);
                sclk = 1'b0;
            end
        end
    endtask

    task automatic csel_low();
        csel = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic csel_high();
        repeat (8) @(negedge clk);
        csel = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input logic [63:0] bytes, input int n, input int meas_idx);
        csel_low();
        for (int k = 0; k < n; k++) send_bits(bytes[63-8*k -: 8], 8, k == meas_idx);
        csel_high();
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; csel = 1'b1; clear_err = 1'b0;
        wr.WrReady = 1'b1;
        lat = -1;
        repeat (4) @(negedge clk);
        chk("rst_valid", wr.WrValid, 0);
        chk("rst_addr", wr.WrAddr, 0);
        chk("rst_data", wr.WrData, 0);
        chk("rst_flags", {overrun, frame_err, busy}, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic two-byte burst with latency measured on the first data byte
        csel_low();
        chk("t1_busy", busy, 1);
        send_bits(8'h01, 8, 0); send_bits(8'h00, 8, 0); send_bits(8'h01, 8, 0);
        send_bits(8'h23, 8, 0); send_bits(8'hAA, 8, 1); send_bits(8'hBB, 8, 0);
        csel_high();
        chk("t1_latency", lat, 4);
        chk("t1_count", cap_q.size(), 2);
        chk("t1_w0", 32'(cap_q[0]), 32'h000123AA);
        chk("t1_w1", 32'(cap_q[1]), 32'h000124BB);
        chk("t1_flags", {overrun, frame_err, busy}, 0);
        cap_q.delete();

        // Address wrap at the top of video memory
        send_frame(64'h01_07_FF_FF_11_22_00_00, 6, -1);
        chk("t2_count", cap_q.size(), 2);
        chk("t2_w0", 32'(cap_q[0]), 32'h07FFFF11);
        chk("t2_w1", 32'(cap_q[1]), 32'h00000022);
        cap_q.delete();

        // Back-pressure: first byte held, the rest dropped
        wr.WrReady = 1'b0;
        send_frame(64'h01_00_00_10_C1_C2_C3_00, 7, -1);
        chk("t3_valid", wr.WrValid, 1);
        chk("t3_addr", wr.WrAddr, 32'h10);
        chk("t3_data", wr.WrData, 32'hC1);
        chk("t3_overrun", overrun, 1);
        chk("t3_frame_err", frame_err, 0);
        pulse_clear();
        chk("t3_overrun_clr", overrun, 0);
        chk("t3_valid_held", wr.WrValid, 1);
        wr.WrReady = 1'b1;
        @(negedge clk);
        chk("t3_valid_drop", wr.WrValid, 0);
        chk("t3_count", cap_q.size(), 1);
        chk("t3_w0", 32'(cap_q[0]), 32'h000010C1);
        cap_q.delete();

        // Frame ending mid-byte
        csel_low();
        send_bits(8'h01, 8, 0); send_bits(8'h00, 8, 0); send_bits(8'h00, 8, 0);
        send_bits(8'h00, 8, 0); send_bits(8'h5A, 8, 0); send_bits(8'hF0, 4, 0);
        csel_high();
        chk("t4_count", cap_q.size(), 1);
        chk("t4_w0", 32'(cap_q[0]), 32'h0000005A);
        chk("t4_frame_err", frame_err, 1);
        chk("t4_idle", 32'(dut.state), 32'(IDLE));
        pulse_clear();
        chk("t4_frame_err_clr", frame_err, 0);
        cap_q.delete();

        // Unknown opcode, then a NOP frame
        send_frame(64'h7E_01_02_00_00_00_00_00, 3, -1);
        chk("t5_bad_count", cap_q.size(), 0);
        chk("t5_bad_frame_err", frame_err, 1);
        pulse_clear();
        send_frame(64'h00_FF_00_00_00_00_00_00, 2, -1);
        chk("t5_nop_count", cap_q.size(), 0);
        chk("t5_nop_flags", {overrun, frame_err}, 0);

        // Asynchronous reset in the middle of a data byte
        wr.WrReady = 1'b0;
        csel_low();
        send_bits(8'h01, 8, 0); send_bits(8'h00, 8, 0); send_bits(8'h00, 8, 0);
        send_bits(8'h07, 8, 0); send_bits(8'hE1, 8, 0); send_bits(8'hE2, 8, 0);
        send_bits(8'hE3, 4, 0);
        chk("t6_pre_valid", wr.WrValid, 1);
        chk("t6_pre_overrun", overrun, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", wr.WrValid, 0);
        chk("t6_rst_addr", wr.WrAddr, 0);
        chk("t6_rst_data", wr.WrData, 0);
        chk("t6_rst_flags", {overrun, frame_err, busy}, 0);
        @(negedge clk);
        csel = 1'b1; sclk = 1'b0; wr.WrReady = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        cap_q.delete();
        send_frame(64'h01_00_00_05_EE_00_00_00, 5, -1);
        chk("t6_count", cap_q.size(), 1);
        chk("t6_w0", 32'(cap_q[0]), 32'h000005EE);
        chk("t6_flags", {overrun, frame_err}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
